ram_port_ctrl: RTL and testbench



---
 rtl/ram_port_ctrl.sv | 110 +++++++++++
 tb/tb_ram_port_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_ctrl.sv
// ============================================================================
// ram_port_ctrl : valid/ready front end for a single-port RAM with tagged
//                 read-latency tracking and a credit-gated response FIFO.
// Revision 1.0
// ============================================================================
`default_nettype none

module ram_port_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int RD_LAT    = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + RD_LAT + 2) + 1;

  logic [ADDR_W-1:0] r_ram_address;
  logic [DATA_W-1:0] r_ram_data;
  logic              r_ram_wren;
  logic [RD_LAT:0]   r_tag;
  logic [DATA_W-1:0] r_fifo [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W-1:0]  w_inflight;
  logic              w_accept;
  logic              w_rd_accept;
  logic              w_push;
  logic              w_pop;

  always_comb begin
    w_inflight = '0;
    for (int k = 0; k <= RD_LAT; k++) begin
      w_inflight = w_inflight + CNT_W'(r_tag[k]);
    end
  end

  // Every accepted read reserves a FIFO slot until popped, so a push can never overflow.
  assign req_ready   = !reset && ((r_count + w_inflight) < CNT_W'(RSP_DEPTH));
  assign rsp_valid   = !reset && (r_count != '0);
  assign rsp_rdata   = rsp_valid ? r_fifo[r_rptr] : '0;

  assign w_accept    = req_valid && req_ready;
  assign w_rd_accept = w_accept && !req_wr;
  assign w_push      = r_tag[RD_LAT];
  assign w_pop       = rsp_valid && rsp_ready;

  // RAM-facing outputs are forced to their idle values for the whole reset cycle.
  assign ram_address = reset ? '0   : r_ram_address;
  assign ram_data    = reset ? '0   : r_ram_data;
  assign ram_wren    = reset ? 1'b0 : r_ram_wren;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_ram_wren    <= 1'b0;
      r_tag         <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
    end else begin
      r_ram_wren <= w_accept && req_wr;
      if (w_accept) begin
        r_ram_address <= req_addr;
        if (req_wr) begin
          r_ram_data <= req_wdata;
        end
      end
      r_tag <= {r_tag[RD_LAT-1:0], w_rd_accept};
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_fifo[r_wptr] <= ram_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_ctrl.sv
// ============================================================================
// tb_ram_port_ctrl : self-checking bench with a RAM model and a queue-based
//                    reference of the request/response channel.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ram_port_ctrl;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 8;
  localparam int RD_LAT    = 2;
  localparam int RSP_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  always #5 clk = ~clk;

  ram_port_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  // Unwritten locations return a recognisable address-derived pattern.
  function automatic logic [31:0] init_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // RAM model: q holds the word RD_LAT edges after the address is sampled.
  logic [31:0] ram_mem  [256];
  bit          ram_vld  [256];
  logic [31:0] ram_pipe [RD_LAT];
  always @(posedge clk) begin
    if (ram_wren) begin
      ram_mem[ram_address] <= ram_data;
      ram_vld[ram_address] <= 1'b1;
    end
    ram_pipe[0] <= ram_vld[ram_address] ? ram_mem[ram_address] : init_word(ram_address);
    for (int k = 1; k < RD_LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
  end
  assign ram_q = ram_pipe[RD_LAT-1];

  // Reference: shadow memory plus a queue of owed responses with their push edge.
  typedef struct { logic [31:0] data; int push_edge; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] shadow [int];
  logic [7:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_wren = 1'b0;
  int          edge_n = 0;
  int          last_pop_edge = -100;
  bit          last_acc, last_pop;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] shadow_rd(input logic [7:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : init_word(a);
  endfunction

  function automatic int n_buffered();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].push_edge <= edge_n) n++;
    return n;
  endfunction

  function automatic bit m_valid();
    if (reset !== 1'b0 || exp_q.size() == 0) return 1'b0;
    return exp_q[0].push_edge <= edge_n;
  endfunction

  function automatic bit m_ready();
    return (reset === 1'b0) && (exp_q.size() < RSP_DEPTH);
  endfunction

  function automatic logic [31:0] m_rdata();
    return m_valid() ? exp_q[0].data : 32'h0;
  endfunction

  // Advance one clock: capture the handshakes, update the reference at the edge.
  task automatic tick();
    logic rst_s, acc_s, pop_s, wr_s;
    logic [7:0]  a_s;
    logic [31:0] d_s;
    #1;
    rst_s = reset;
    acc_s = req_valid && req_ready;
    pop_s = rsp_valid && rsp_ready;
    wr_s  = req_wr;
    a_s   = req_addr;
    d_s   = req_wdata;
    @(posedge clk);
    edge_n++;
    last_acc = acc_s;
    last_pop = pop_s;
    if (rst_s) begin
      exp_q.delete();
      m_addr = '0; m_data = '0; m_wren = 1'b0;
    end else begin
      if (pop_s) begin
        last_pop_edge = edge_n;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      m_wren = acc_s && wr_s;
      if (acc_s) begin
        m_addr = a_s;
        if (wr_s) begin
          m_data = d_s;
          shadow[int'(a_s)] = d_s;
        end else begin
          exp_q.push_back('{shadow_rd(a_s), edge_n + 1 + RD_LAT});
        end
      end
      checks++;
      if (n_buffered() > RSP_DEPTH) begin
        errors++;
        $display("FAIL fifo_overflow: buffered=%0d limit=%0d", n_buffered(), RSP_DEPTH);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "response fifo overrun");
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (req_ready !== 1'b0)   begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0)   begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0)  begin errors++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    checks++; if (ram_wren !== 1'b0)    begin errors++; $display("FAIL rst_ram_wren: got %b want 0", ram_wren); end
    checks++; if (ram_address !== 8'h0) begin errors++; $display("FAIL rst_ram_address: got %h want 0", ram_address); end
    checks++; if (ram_data !== 32'h0)   begin errors++; $display("FAIL rst_ram_data: got %h want 0", ram_data); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1)   begin errors++; $display("FAIL rst_ready_rise: got %b want 1", req_ready); end
  endtask

  task automatic test_write_read();
    int a_edge, k;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h10; req_wdata = 32'hDEADBEEF;
    tick();
    checks++; if (last_acc !== 1'b1)        begin errors++; $display("FAIL wr_accept: got %b want 1", last_acc); end
    checks++; if (ram_wren !== 1'b1)        begin errors++; $display("FAIL wr_pulse: got %b want 1", ram_wren); end
    checks++; if (ram_address !== 8'h10)    begin errors++; $display("FAIL wr_addr: got %h want 10", ram_address); end
    checks++; if (ram_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data: got %h want deadbeef", ram_data); end
    req_wr = 1'b0;
    tick();
    a_edge = edge_n;
    req_valid = 1'b0;
    checks++; if (ram_wren !== 1'b0)        begin errors++; $display("FAIL wr_pulse_end: got %b want 0", ram_wren); end
    checks++; if (ram_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_holds_data: got %h want deadbeef", ram_data); end
    checks++; if (rsp_valid !== 1'b0)       begin errors++; $display("FAIL rd_lat_k0: got %b want 0", rsp_valid); end
    for (int c = 0; c < 4; c++) begin
      tick();
      k = edge_n - a_edge;
      checks++;
      if (rsp_valid !== (k >= RD_LAT + 1)) begin
        errors++; $display("FAIL rd_latency k=%0d: got %b want %b", k, rsp_valid, (k >= RD_LAT + 1));
      end
    end
    checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rsp_rdata); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0)       begin errors++; $display("FAIL rd_popped: got %b want 0", rsp_valid); end
  endtask

  task automatic test_raw_b2b();
    bit found = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h20; req_wdata = 32'h11111111;
    tick();
    req_wr = 1'b0;
    tick();
    checks++; if (last_acc !== 1'b1) begin errors++; $display("FAIL raw_rd_accept: got %b want 1", last_acc); end
    req_valid = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (rsp_valid === 1'b1) begin
        found = 1'b1;
        checks++;
        if (rsp_rdata !== 32'h11111111) begin errors++; $display("FAIL raw_data: got %h want 11111111", rsp_rdata); end
      end
      tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL raw_timeout: got no response want 1"); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_credit_stall();
    int acc_n = 0, got = 0, prev_pop;
    rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'(acc_n);
      tick();
      if (last_acc) acc_n++;
    end
    checks++; if (acc_n != RSP_DEPTH)  begin errors++; $display("FAIL stall_accepts: got %0d want %0d", acc_n, RSP_DEPTH); end
    checks++; if (req_ready !== 1'b0)  begin errors++; $display("FAIL stall_ready: got %b want 0", req_ready); end
    req_wr = 1'b1; req_addr = 8'h40; req_wdata = 32'hCAFEF00D;
    tick();
    checks++; if (last_acc !== 1'b0)   begin errors++; $display("FAIL stall_write_accept: got %b want 0", last_acc); end
    checks++; if (ram_wren !== 1'b0)   begin errors++; $display("FAIL stall_write_wren: got %b want 0", ram_wren); end
    req_wr = 1'b0; req_addr = 8'(acc_n);
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      checks++; if (req_ready !== m_ready()) begin errors++; $display("FAIL stall_ready_c%0d: got %b want %b", c, req_ready, m_ready()); end
      checks++; if (rsp_valid !== m_valid()) begin errors++; $display("FAIL stall_valid_c%0d: got %b want %b", c, rsp_valid, m_valid()); end
      if (rsp_valid === 1'b1) begin
        checks++;
        if (rsp_rdata !== shadow_rd(8'(got))) begin
          errors++; $display("FAIL stall_order_%0d: got %h want %h", got, rsp_rdata, shadow_rd(8'(got)));
        end
        got++;
      end
      prev_pop = last_pop_edge;
      tick();
      if (last_acc) begin
        checks++;
        if (edge_n != prev_pop + 1) begin errors++; $display("FAIL credit_release: accept edge %0d want %0d", edge_n, prev_pop + 1); end
        acc_n++;
        if (acc_n >= 6) req_valid = 1'b0;
        else req_addr = 8'(acc_n);
      end
    end
    checks++; if (got != 6) begin errors++; $display("FAIL stall_responses: got %0d want 6", got); end
    req_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_full_wrap();
    int pops = 0;
    rsp_ready = 1'b0; req_wr = 1'b0;
    for (int i = 0; i < RSP_DEPTH; i++) begin
      req_valid = 1'b1; req_addr = 8'($urandom_range(0, 255));
      tick();
      checks++; if (last_acc !== 1'b1) begin errors++; $display("FAIL fill_accept_%0d: got %b want 1", i, last_acc); end
    end
    req_valid = 1'b0;
    for (int i = 0; i <= RD_LAT; i++) tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", rsp_valid); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", req_ready); end
    rsp_ready = 1'b1; req_valid = 1'b1;
    for (int c = 0; c < 80 && pops < 3 * RSP_DEPTH; c++) begin
      req_addr = 8'($urandom_range(0, 255));
      checks++; if (rsp_valid !== m_valid()) begin errors++; $display("FAIL wrap_valid_c%0d: got %b want %b", c, rsp_valid, m_valid()); end
      checks++; if (rsp_rdata !== m_rdata()) begin errors++; $display("FAIL wrap_data_c%0d: got %h want %h", c, rsp_rdata, m_rdata()); end
      checks++; if (req_ready !== m_ready()) begin errors++; $display("FAIL wrap_ready_c%0d: got %b want %b", c, req_ready, m_ready()); end
      tick();
      if (last_pop) pops++;
    end
    checks++; if (pops < 3 * RSP_DEPTH) begin errors++; $display("FAIL wrap_timeout: pops %0d want %0d", pops, 3 * RSP_DEPTH); end
    req_valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      checks++; if (rsp_rdata !== m_rdata()) begin errors++; $display("FAIL wrap_drain_c%0d: got %h want %h", c, rsp_rdata, m_rdata()); end
      tick();
    end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %b want 0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_stream16();
    int sent = 0, got = 0, first_acc = -1;
    rsp_ready = 1'b1; req_wr = 1'b0;
    for (int c = 0; c < 100 && got < 16; c++) begin
      req_valid = (sent < 16);
      req_addr  = 8'h80 + 8'(sent);
      checks++; if (rsp_valid !== m_valid()) begin errors++; $display("FAIL stream_valid_c%0d: got %b want %b", c, rsp_valid, m_valid()); end
      if (rsp_valid === 1'b1) begin
        if (got == 0) begin
          checks++;
          if (edge_n != first_acc + RD_LAT + 1) begin errors++; $display("FAIL stream_first: edge %0d want %0d", edge_n, first_acc + RD_LAT + 1); end
        end
        checks++;
        if (rsp_rdata !== shadow_rd(8'h80 + 8'(got))) begin
          errors++; $display("FAIL stream_data_%0d: got %h want %h", got, rsp_rdata, shadow_rd(8'h80 + 8'(got)));
        end
        got++;
      end
      tick();
      if (last_acc) begin
        if (sent == 0) first_acc = edge_n;
        sent++;
      end
    end
    checks++; if (got != 16) begin errors++; $display("FAIL stream_count: got %0d want 16", got); end
    req_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 120; c++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_wr    = ($urandom_range(0, 9) < 3);
      req_addr  = 8'h30 + 8'($urandom_range(0, 7));
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 9) < 6);
      checks++; if (req_ready !== m_ready())  begin errors++; $display("FAIL rnd_ready_c%0d: got %b want %b", c, req_ready, m_ready()); end
      checks++; if (rsp_valid !== m_valid())  begin errors++; $display("FAIL rnd_valid_c%0d: got %b want %b", c, rsp_valid, m_valid()); end
      checks++; if (rsp_rdata !== m_rdata())  begin errors++; $display("FAIL rnd_data_c%0d: got %h want %h", c, rsp_rdata, m_rdata()); end
      checks++; if (ram_wren !== m_wren)      begin errors++; $display("FAIL rnd_wren_c%0d: got %b want %b", c, ram_wren, m_wren); end
      checks++; if (ram_address !== m_addr)   begin errors++; $display("FAIL rnd_addr_c%0d: got %h want %h", c, ram_address, m_addr); end
      checks++; if (ram_data !== m_data)      begin errors++; $display("FAIL rnd_wdata_c%0d: got %h want %h", c, ram_data, m_data); end
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      checks++; if (rsp_rdata !== m_rdata()) begin errors++; $display("FAIL rnd_drain_c%0d: got %h want %h", c, rsp_rdata, m_rdata()); end
      tick();
    end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_empty: got %b want 0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    rsp_ready = 1'b0; req_wr = 1'b0;
    req_valid = 1'b1; req_addr = 8'h50;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    req_valid = 1'b1; req_addr = 8'h51;
    tick();
    req_addr = 8'h52;
    tick();
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1)   begin errors++; $display("FAIL mid_buffered: got %b want 1", rsp_valid); end
    reset = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0)   begin errors++; $display("FAIL mid_rst_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0)  begin errors++; $display("FAIL mid_rst_rdata: got %h want 0", rsp_rdata); end
    checks++; if (ram_wren !== 1'b0)    begin errors++; $display("FAIL mid_rst_wren: got %b want 0", ram_wren); end
    checks++; if (req_ready !== 1'b0)   begin errors++; $display("FAIL mid_rst_ready: got %b want 0", req_ready); end
    checks++; if (ram_address !== 8'h0) begin errors++; $display("FAIL mid_rst_addr: got %h want 0", ram_address); end
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_c%0d: got %b want 0", c, rsp_valid); end
      tick();
    end
    req_valid = 1'b1; req_addr = 8'h52;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (rsp_valid === 1'b1) begin
        found = 1'b1;
        checks++;
        if (rsp_rdata !== init_word(8'h52)) begin errors++; $display("FAIL mid_fresh_data: got %h want %h", rsp_rdata, init_word(8'h52)); end
      end
      tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_fresh_timeout: got no response want 1"); end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_raw_b2b();
    test_credit_stall();
    test_full_wrap();
    test_stream16();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
